load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: max cycles spent in REQ or WAIT before abort.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports lsu_valid in 1 (core access request), lsu_we in 1 (1 = store), funct3 in 3 (access size/sign), addr in 32 (byte address), wdata in 32 (store data).
REQ-005 SHALL have ports lsu_stall out 1 (hold core PC), lsu_done out 1 (completion pulse), rdata out 32 (aligned, extended load result), lsu_err out 1 (access error, valid with lsu_done).
REQ-006 SHALL have ports mem_req out 1, mem_we out 1, mem_addr out 32 (word aligned, [1:0]=0), mem_be out 4, mem_wdata out 32, mem_gnt in 1, mem_rvalid in 1, mem_rdata in 32.

Function
REQ-007 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-008 IDLE: on lsu_valid=1, SHALL latch addr, funct3, lsu_we and wdata; illegal funct3 or trapped misalignment -> DONE with error; else -> REQ.
REQ-009 Legal funct3: loads 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000 sb, 001 sh, 010 sw; all others illegal, with no mem_req.
REQ-010 REQ: mem_req=1, all mem_* outputs stable until mem_gnt=1; on gnt, stores -> DONE, loads -> WAIT unless mem_rvalid is also 1, in which case data is captured and the FSM goes -> DONE.
REQ-011 mem_rvalid SHALL be ignored in IDLE, DONE, and in REQ before gnt.
REQ-012 WAIT: on mem_rvalid=1 SHALL capture the extracted load data into rdata and go -> DONE.
REQ-013 DONE: lsu_done=1 for exactly one cycle, lsu_stall=0, then -> IDLE.
REQ-014 lsu_stall SHALL be 1 in IDLE while lsu_valid=1, in REQ, and in WAIT; otherwise 0.
REQ-015 Store byte enables: sb be=4'b0001<<addr[1:0], wdata byte replicated x4; sh be=4'b0011<<{addr[1],1'b0}, halfword replicated x2; sw be=4'b1111.
REQ-016 Loads SHALL select the byte or halfword by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-017 A cycle counter SHALL clear on entry to REQ and increment in REQ/WAIT; reaching TIMEOUT_CYCLES SHALL drop mem_req and go -> DONE with lsu_err=1 and rdata=0.
REQ-018 rdata SHALL hold its value until the next load completes; error completions SHALL write rdata=0.
REQ-019 A new lsu_valid SHALL be accepted only in IDLE.

Reset
REQ-020 While reset=0, the FSM SHALL be IDLE, the counter 0, and every output 0, including mid-transaction; mem_req SHALL drop asynchronously.
REQ-021 After reset release, the first rising edge SHALL sample lsu_valid normally.

Configuration
REQ-022 With MISALIGN_TRAP_EN defined: lh/lhu/sh with addr[0]=1, or lw/sw with addr[1:0]!=0, SHALL complete through DONE with lsu_err=1 and no mem_req.
REQ-023 Without MISALIGN_TRAP_EN: the address SHALL be rounded down to natural alignment and the access performed with no error.

Structure
REQ-024 Package lsu_pkg SHALL hold the FSM state enum, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the TIMEOUT_CYCLES default.
REQ-025 The combinational load extractor SHALL be sub-module lsu_load_align (mem_rdata, addr[1:0], funct3 -> 32-bit result).

Verification
REQ-026 sb, addr 0x63, wdata 0x000000AB, gnt immediate -> mem_addr 0x60, mem_be 4'b1000, mem_wdata 0xABABABAB, lsu_done 2 cycles after lsu_valid.
REQ-027 lb/lbu, addr 0x61, mem_rdata 0x12C38077, rvalid with gnt -> rdata 0xFFFFFF80 / 0x00000080.
REQ-028 lh, addr 0x62, mem_rdata 0x80011234, gnt then rvalid 3 cycles later -> rdata 0xFFFF8001, lsu_stall high throughout WAIT.
REQ-029 lw, addr 0x66: with macro -> lsu_err=1, no mem_req, done 1 cycle after valid; without macro -> mem_addr 0x64, no error.
REQ-030 Load with gnt never asserted, TIMEOUT_CYCLES=16 -> mem_req high 16 cycles, then lsu_done with lsu_err=1 and rdata 0.
REQ-031 reset pulled low during WAIT -> mem_req 0 immediately; next lw at 0x40 after release completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM states, funct3 encodings,
// timeout default and access-size helpers.
package lsu_pkg;

    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    // Stores only exist in the signed-size encodings; unsigned variants are load-only.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3[1:0] == 2'b01) && lo[0]) || ((f3[1:0] == 2'b10) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extractor: picks the byte/halfword at the given offset
// of the memory word and sign- or zero-extends it according to funct3.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [31:0] shifted;

    always_comb begin
        shifted = mem_rdata >> {addr_lo, 3'b000};
        case (funct3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'b0, shifted[7:0]};
            F3_HU:   result = {16'b0, shifted[15:0]};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the core to a req/gnt/rvalid memory port.
// Define MISALIGN_TRAP_EN to trap misaligned accesses instead of rounding the address down.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        lsu_valid,
    input  logic        lsu_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic [31:0] rdata,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

`ifdef MISALIGN_TRAP_EN
    localparam bit MISALIGN_TRAP = 1'b1;
`else
    localparam bit MISALIGN_TRAP = 1'b0;
`endif

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic              we_q, we_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       addr_al_c;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic              trap_c;
    logic              timeout_c;
    logic [31:0]       load_res;

    lsu_load_align u_load_align (
        .mem_rdata (mem_rdata),
        .addr_lo   (lo_q),
        .funct3    (f3_q),
        .result    (load_res)
    );

    // Naturally aligned address, byte enables and replicated store data for the incoming request
    always_comb begin
        addr_al_c = addr;
        be_c      = 4'b1111;
        wdata_c   = wdata;
        case (funct3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                addr_al_c = {addr[31:1], 1'b0};
                be_c      = 4'b0011 << {addr[1], 1'b0};
                wdata_c   = {2{wdata[15:0]}};
            end
            default: addr_al_c = {addr[31:2], 2'b00};
        endcase
        trap_c = MISALIGN_TRAP && f3_misaligned(funct3, addr[1:0]);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        f3_d        = f3_q;
        lo_d        = lo_q;
        we_d        = we_q;
        mem_req_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        timeout_c   = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

        case (state_q)
            ST_IDLE: begin
                if (lsu_valid) begin
                    f3_d = funct3;
                    lo_d = addr_al_c[1:0];
                    we_d = lsu_we;
                    if (!f3_legal(lsu_we, funct3) || trap_c) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d     = ST_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = lsu_we;
                        mem_addr_d  = {addr_al_c[31:2], 2'b00};
                        mem_be_d    = be_c;
                        mem_wdata_d = wdata_c;
                    end
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A grant that does not finish the access cannot outlive the timeout budget
                if (mem_gnt && (we_q || mem_rvalid)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    if (!we_q) begin
                        rdata_d = load_res;
                    end
                end else if (timeout_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else if (mem_gnt) begin
                    state_d = ST_WAIT;
                end else begin
                    mem_req_d = 1'b1;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mem_rvalid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    rdata_d = load_res;
                end else if (timeout_c) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            f3_q        <= '0;
            lo_q        <= '0;
            we_q        <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            f3_q        <= f3_d;
            lo_q        <= lo_d;
            we_q        <= we_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    // Stall must rise in the same cycle the core presents a request, so it decodes lsu_valid directly
    assign lsu_stall = reset & (((state_q == ST_IDLE) & lsu_valid) |
                                (state_q == ST_REQ) | (state_q == ST_WAIT));

    assign lsu_done  = done_q;
    assign lsu_err   = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset sequences and
// randomized accesses checked against an arithmetic reference model.
`timescale 1ns/1ps
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int unsigned TO = 16;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        lsu_valid, lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        lsu_stall, lsu_done, lsu_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .lsu_valid(lsu_valid), .lsu_we(lsu_we), .funct3(funct3), .addr(addr), .wdata(wdata),
        .lsu_stall(lsu_stall), .lsu_done(lsu_done), .rdata(rdata), .lsu_err(lsu_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] hold_rdata;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gnt_dly;
        int          rv_dly;
        logic [31:0] mrdata;
        logic        no_req;
        logic        exp_err;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, input int g, input int r,
                                input logic [31:0] mrd, input logic nr, input logic er,
                                input logic [31:0] ea, input logic [3:0] eb,
                                input logic [31:0] ew, input logic [31:0] er_data);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.gnt_dly = g; v.rv_dly = r;
        v.mrdata = mrd; v.no_req = nr; v.exp_err = er; v.exp_addr = ea; v.exp_be = eb;
        v.exp_wdata = ew; v.exp_rdata = er_data;
        return v;
    endfunction

    // One access: memory responds after gnt_dly request cycles and rv_dly cycles after grant
    task automatic run_txn(input vec_t v);
        int need, exp_req, exp_lat, cyc, req_cnt, wait_cnt;
        bit done_seen;
        need = v.we ? v.gnt_dly + 1 : v.gnt_dly + 1 + v.rv_dly;
        if (v.no_req) begin
            exp_req = 0; exp_lat = 1;
        end else if (need > int'(TO)) begin
            exp_req = (v.gnt_dly + 1 < int'(TO)) ? v.gnt_dly + 1 : int'(TO);
            exp_lat = int'(TO) + 1;
        end else begin
            exp_req = v.gnt_dly + 1; exp_lat = need + 1;
        end

        @(negedge clk);
        lsu_valid = 1'b1; lsu_we = v.we; funct3 = v.f3; addr = v.addr; wdata = v.wdata;
        #1 chk("stall_on_valid", 32'(lsu_stall), 32'd1);
        @(posedge clk); #1;
        lsu_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom_range(0, 7));
        cyc = 1; req_cnt = 0; wait_cnt = 0; done_seen = 1'b0;
        while (cyc <= 40 && !done_seen) begin
            if (lsu_done) begin
                done_seen = 1'b1;
            end else begin
                chk("stall_busy", 32'(lsu_stall), 32'd1);
                if (mem_req) begin
                    req_cnt++;
                    chk("mem_addr", mem_addr, v.exp_addr);
                    chk("mem_we", 32'(mem_we), 32'(v.we));
                    if (v.we) begin
                        chk("mem_be", 32'(mem_be), 32'(v.exp_be));
                        chk("mem_wdata", mem_wdata, v.exp_wdata);
                    end
                    if (req_cnt - 1 == v.gnt_dly) begin
                        mem_gnt = 1'b1; mem_rvalid = (v.rv_dly == 0); mem_rdata = v.mrdata;
                    end else begin
                        mem_gnt = 1'b0; mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
                    end
                end else begin
                    mem_gnt = 1'b0;
                    wait_cnt++;
                    mem_rvalid = (wait_cnt == v.rv_dly);
                    mem_rdata = mem_rvalid ? v.mrdata : $urandom;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("done_seen", 32'(done_seen), 32'd1);
        chk("done_latency", 32'(cyc), 32'(exp_lat));
        chk("req_cycles", 32'(req_cnt), 32'(exp_req));
        chk("lsu_err", 32'(lsu_err), 32'(v.exp_err));
        chk("rdata", rdata, v.exp_rdata);
        chk("stall_done", 32'(lsu_stall), 32'd0);
        // Responses seen outside REQ/WAIT must be ignored
        mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = $urandom;
        @(posedge clk); #1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        chk("done_pulse", 32'(lsu_done), 32'd0);
        chk("err_clear", 32'(lsu_err), 32'd0);
        chk("rdata_hold", rdata, v.exp_rdata);
        chk("req_idle", 32'(mem_req), 32'd0);
    endtask

    // Reference model: expected bus fields and result from access-size arithmetic
    task automatic rand_txn();
        vec_t v;
        int unsigned nb, off, need;
        logic legal, mis, err;
        logic [31:0] a_al, lv, mask;
        v.we = 1'($urandom_range(0, 1));
        v.f3 = 3'($urandom_range(0, 7));
        v.addr = $urandom; v.wdata = $urandom; v.mrdata = $urandom;
        v.gnt_dly = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 20)) : int'($urandom_range(0, 3));
        v.rv_dly  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 16)) : int'($urandom_range(0, 3));
        nb = 32'd1 << v.f3[1:0];
        legal = (v.f3 <= 3'd2) || (!v.we && (v.f3 == 3'd4 || v.f3 == 3'd5));
        mis = (v.addr % nb) != 0;
        a_al = v.addr - (v.addr % nb);
        off = a_al % 4;
        v.exp_addr = a_al - off;
        v.exp_be = 4'(((32'd1 << nb) - 1) << off);
        v.exp_wdata = (nb == 1) ? v.wdata[7:0] * 32'h01010101 :
                      (nb == 2) ? v.wdata[15:0] * 32'h00010001 : v.wdata;
        v.no_req = !legal || (TRAP_EN && mis);
        need = v.we ? v.gnt_dly + 1 : v.gnt_dly + 1 + v.rv_dly;
        err = v.no_req || (need > TO);
        if (err) begin
            hold_rdata = 32'd0;
        end else if (!v.we) begin
            mask = (nb >= 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 1;
            lv = (v.mrdata >> (8 * off)) & mask;
            if (!v.f3[2] && nb < 4 && lv[8 * nb - 1]) lv = lv - (32'd1 << (8 * nb));
            hold_rdata = lv;
        end
        v.exp_err = err;
        v.exp_rdata = hold_rdata;
        run_txn(v);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; lsu_valid = 1'b0; lsu_we = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_done", 32'(lsu_done), 32'd0);
        chk("rst_err", 32'(lsu_err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        reset = 1'b1;

        //      we    f3     addr          wdata         g  r   mrdata        nr  err  exp_addr      be       exp_wdata     exp_rdata
        tbl.push_back(mk(1'b1, F3_B,  32'h63, 32'h0000_00AB, 0, 0, 32'h0,        0, 0, 32'h60, 4'b1000, 32'hABAB_ABAB, 32'h0));
        tbl.push_back(mk(1'b0, F3_B,  32'h61, 32'h0,         0, 0, 32'h12C38077, 0, 0, 32'h60, 4'b0,    32'h0,        32'hFFFF_FF80));
        tbl.push_back(mk(1'b0, F3_BU, 32'h61, 32'h0,         0, 0, 32'h12C38077, 0, 0, 32'h60, 4'b0,    32'h0,        32'h0000_0080));
        tbl.push_back(mk(1'b0, F3_H,  32'h62, 32'h0,         0, 3, 32'h80011234, 0, 0, 32'h60, 4'b0,    32'h0,        32'hFFFF_8001));
`ifdef MISALIGN_TRAP_EN
        tbl.push_back(mk(1'b0, F3_W,  32'h66, 32'h0,         0, 0, 32'hDEADBEEF, 1, 1, 32'h0,  4'b0,    32'h0,        32'h0));
`else
        tbl.push_back(mk(1'b0, F3_W,  32'h66, 32'h0,         0, 0, 32'hDEADBEEF, 0, 0, 32'h64, 4'b0,    32'h0,        32'hDEADBEEF));
`endif
        tbl.push_back(mk(1'b0, F3_HU, 32'h60, 32'h0,         2, 1, 32'h1234F00D, 0, 0, 32'h60, 4'b0,    32'h0,        32'h0000_F00D));
        tbl.push_back(mk(1'b1, F3_W,  32'h44, 32'h11223344,  2, 0, 32'h0,        0, 0, 32'h44, 4'b1111, 32'h11223344, 32'h0000_F00D));
        tbl.push_back(mk(1'b1, F3_H,  32'h42, 32'h1234ABCD,  1, 0, 32'h0,        0, 0, 32'h40, 4'b1100, 32'hABCD_ABCD, 32'h0000_F00D));
        tbl.push_back(mk(1'b0, 3'b011, 32'h50, 32'h0,        0, 0, 32'h0,        1, 1, 32'h0,  4'b0,    32'h0,        32'h0));
        tbl.push_back(mk(1'b1, F3_BU, 32'h50, 32'h0,         0, 0, 32'h0,        1, 1, 32'h0,  4'b0,    32'h0,        32'h0));
        tbl.push_back(mk(1'b1, F3_B,  32'h61, 32'h0000_005A, 0, 0, 32'h0,        0, 0, 32'h60, 4'b0010, 32'h5A5A_5A5A, 32'h0));
        tbl.push_back(mk(1'b0, F3_W,  32'h84, 32'h0,         1, 2, 32'hCAFEBABE, 0, 0, 32'h84, 4'b0,    32'h0,        32'hCAFE_BABE));
        tbl.push_back(mk(1'b0, F3_W,  32'h40, 32'h0,       100, 0, 32'h0,        0, 1, 32'h40, 4'b0,    32'h0,        32'h0));
        tbl.push_back(mk(1'b0, F3_BU, 32'h83, 32'h0,         0, 0, 32'hA5000000, 0, 0, 32'h80, 4'b0,    32'h0,        32'h0000_00A5));
        tbl.push_back(mk(1'b0, F3_W,  32'h80, 32'h0,         0, 20, 32'h0,       0, 1, 32'h80, 4'b0,    32'h0,        32'h0));
        tbl.push_back(mk(1'b0, F3_W,  32'h88, 32'h0,         0, 1, 32'hCAFEBABE, 0, 0, 32'h88, 4'b0,    32'h0,        32'hCAFE_BABE));
        foreach (tbl[i]) run_txn(tbl[i]);

        // Reset while a load waits for its response
        @(negedge clk);
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = F3_W; addr = 32'h100;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        chk("rw_req", 32'(mem_req), 32'd1);
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        mem_gnt = 1'b0;
        chk("rw_wait_stall", 32'(lsu_stall), 32'd1);
        chk("rw_wait_req", 32'(mem_req), 32'd0);
        #2 reset = 1'b0; lsu_valid = 1'b1;
        #1;
        chk("rw_rdata", rdata, 32'd0);
        chk("rw_stall", 32'(lsu_stall), 32'd0);
        chk("rw_done", 32'(lsu_done), 32'd0);
        chk("rw_addr", mem_addr, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rw_held_req", 32'(mem_req), 32'd0);
        chk("rw_held_stall", 32'(lsu_stall), 32'd0);
        reset = 1'b1; lsu_valid = 1'b0;

        // Reset while the request is outstanding must drop mem_req without a clock edge
        @(negedge clk);
        lsu_valid = 1'b1; lsu_we = 1'b0; funct3 = F3_W; addr = 32'h200;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
        chk("rr_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("rr_async_drop", 32'(mem_req), 32'd0);
        chk("rr_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_txn(mk(1'b0, F3_W, 32'h40, 32'h0, 0, 1, 32'h13579BDF, 0, 0, 32'h40, 4'b0, 32'h0, 32'h13579BDF));

        hold_rdata = 32'h13579BDF;
        for (int n = 0; n < 40; n++) rand_txn();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
